// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared constants, labels and FSM states for the HDC classifier
package hdc_pkg;

  localparam int DEFAULT_DIMENSIONS = 10000;
  localparam int DEFAULT_PAR_BITS   = 10;

  localparam logic LABEL_NONSEIZURE = 1'b0;
  localparam logic LABEL_SEIZURE    = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESOLVE = 2'd2
  } state_t;

endpackage

// File: rtl/hv_chunk_hamming.sv
// rtl/hv_chunk_hamming.sv - popcount of the masked XOR of two hypervector slices
module hv_chunk_hamming
  import hdc_pkg::*;
#(
  parameter int PAR_BITS = DEFAULT_PAR_BITS,
  parameter int CNT_W    = $clog2(PAR_BITS + 1)
) (
  input  logic [PAR_BITS-1:0] slice_a,
  input  logic [PAR_BITS-1:0] slice_b,
  input  logic [PAR_BITS-1:0] valid_mask,
  output logic [CNT_W-1:0]    count
);

  logic [PAR_BITS-1:0] diff;

  // Bits beyond the hypervector end are masked so they never contribute a mismatch
  always_comb begin
    diff  = (slice_a ^ slice_b) & valid_mask;
    count = '0;
    for (int i = 0; i < PAR_BITS; i++) begin
      count = count + CNT_W'(diff[i]);
    end
  end

endmodule

// File: rtl/assoc_search.sv
// rtl/assoc_search.sv - chunked Hamming-distance classifier against two class hypervectors
module assoc_search
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = DEFAULT_DIMENSIONS,
  parameter int PAR_BITS   = DEFAULT_PAR_BITS
) (
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic                                 en,
  input  logic [DIMENSIONS-1:0]                hv_query,
  input  logic [DIMENSIONS-1:0]                hv_nonseizure,
  input  logic [DIMENSIONS-1:0]                hv_seizure,
  output logic                                 done,
  output logic                                 label,
  output logic [$clog2(DIMENSIONS+1)-1:0]      dist_nonseizure,
  output logic [$clog2(DIMENSIONS+1)-1:0]      dist_seizure
);

  localparam int NUM_CHUNKS = (DIMENSIONS + PAR_BITS - 1) / PAR_BITS;
  localparam int DIST_W     = $clog2(DIMENSIONS + 1);
  localparam int CNT_W      = $clog2(PAR_BITS + 1);
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  // Operands are stored zero-padded to a whole number of chunks so every
  // slice of the last chunk stays inside the register.
  localparam int PAD_W      = NUM_CHUNKS * PAR_BITS;

  state_t               state, state_nxt;
  logic [CHUNK_W-1:0]   chunk;
  logic [DIST_W-1:0]    acc_ns, acc_s;
  logic [PAD_W-1:0]     q_r, ns_r, s_r;

  logic                 load, step, resolve, last_chunk;
  int                   base;
  logic [PAR_BITS-1:0]  q_slice, ns_slice, s_slice, valid_mask;
  logic [CNT_W-1:0]     cnt_ns, cnt_s;

  assign last_chunk = (chunk == CHUNK_W'(NUM_CHUNKS - 1));

  // Select the current chunk of each operand and mask positions past DIMENSIONS
  always_comb begin
    base     = int'(chunk) * PAR_BITS;
    q_slice  = q_r[base +: PAR_BITS];
    ns_slice = ns_r[base +: PAR_BITS];
    s_slice  = s_r[base +: PAR_BITS];
    valid_mask = '0;
    for (int i = 0; i < PAR_BITS; i++) begin
      valid_mask[i] = (base + i < DIMENSIONS);
    end
  end

  hv_chunk_hamming #(.PAR_BITS(PAR_BITS), .CNT_W(CNT_W)) u_ham_ns (
    .slice_a    (q_slice),
    .slice_b    (ns_slice),
    .valid_mask (valid_mask),
    .count      (cnt_ns)
  );

  hv_chunk_hamming #(.PAR_BITS(PAR_BITS), .CNT_W(CNT_W)) u_ham_s (
    .slice_a    (q_slice),
    .slice_b    (s_slice),
    .valid_mask (valid_mask),
    .count      (cnt_s)
  );

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath strobes; en is only looked at while idle
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    resolve   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          load      = 1'b1;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        step = 1'b1;
        if (last_chunk) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        resolve   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, chunk walk and distance accumulation
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q_r    <= '0;
      ns_r   <= '0;
      s_r    <= '0;
      chunk  <= '0;
      acc_ns <= '0;
      acc_s  <= '0;
    end else if (load) begin
      q_r    <= PAD_W'(hv_query);
      ns_r   <= PAD_W'(hv_nonseizure);
      s_r    <= PAD_W'(hv_seizure);
      chunk  <= '0;
      acc_ns <= '0;
      acc_s  <= '0;
    end else if (step) begin
      acc_ns <= acc_ns + DIST_W'(cnt_ns);
      acc_s  <= acc_s + DIST_W'(cnt_s);
      chunk  <= last_chunk ? '0 : chunk + 1'b1;
    end
  end

  // Results only change on the resolve cycle; ties resolve to nonseizure
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done            <= 1'b1;
      label           <= LABEL_NONSEIZURE;
      dist_nonseizure <= '0;
      dist_seizure    <= '0;
    end else if (load) begin
      done <= 1'b0;
    end else if (resolve) begin
      done            <= 1'b1;
      dist_nonseizure <= acc_ns;
      dist_seizure    <= acc_s;
      label           <= (acc_s < acc_ns) ? LABEL_SEIZURE : LABEL_NONSEIZURE;
    end
  end

endmodule

// File: tb/tb_assoc_search.sv
// tb/tb_assoc_search.sv - directed self-checking bench for assoc_search
module tb_assoc_search;

  logic clk = 1'b0;
  logic nrst;

  always #5 clk = ~clk;

  // Instance A: 100 bits / 10 per chunk
  logic        en_a;
  logic [99:0] q_a, ns_a, s_a;
  logic        done_a, label_a;
  logic [6:0]  dns_a, ds_a;

  // Instance B: 95 bits / 10 per chunk (partial last chunk)
  logic        en_b;
  logic [94:0] q_b, ns_b, s_b;
  logic        done_b, label_b;
  logic [6:0]  dns_b, ds_b;

  // Instance C: default 10000 bits / 10 per chunk
  logic          en_c;
  logic [9999:0] q_c, ns_c, s_c;
  logic          done_c, label_c;
  logic [13:0]   dns_c, ds_c;

  assoc_search #(.DIMENSIONS(100), .PAR_BITS(10)) u_dut_a (
    .clk(clk), .nrst(nrst), .en(en_a),
    .hv_query(q_a), .hv_nonseizure(ns_a), .hv_seizure(s_a),
    .done(done_a), .label(label_a),
    .dist_nonseizure(dns_a), .dist_seizure(ds_a)
  );

  assoc_search #(.DIMENSIONS(95), .PAR_BITS(10)) u_dut_b (
    .clk(clk), .nrst(nrst), .en(en_b),
    .hv_query(q_b), .hv_nonseizure(ns_b), .hv_seizure(s_b),
    .done(done_b), .label(label_b),
    .dist_nonseizure(dns_b), .dist_seizure(ds_b)
  );

  assoc_search u_dut_c (
    .clk(clk), .nrst(nrst), .en(en_c),
    .hv_query(q_c), .hv_nonseizure(ns_c), .hv_seizure(s_c),
    .done(done_c), .label(label_c),
    .dist_nonseizure(dns_c), .dist_seizure(ds_c)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int hd(input logic [9999:0] a, input logic [9999:0] b);
    logic [9999:0] x;
    int n;
    x = a ^ b;
    n = 0;
    for (int i = 0; i < 10000; i++) n += int'(x[i]);
    return n;
  endfunction

  function automatic logic done_of(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Counts edges after E0 until done is seen high, bounded by limit
  task automatic wait_done(input int which, input int limit, output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done_of(which) && edges < limit);
  endtask

  function automatic logic [99:0] rand100();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[99:0];
  endfunction

  // One full operation on instance A with model-derived expectations
  task automatic run_a(input string tag, input logic [99:0] q, input logic [99:0] ns,
                       input logic [99:0] s);
    int edges, e_ns, e_s;
    e_ns = hd(10000'(q), 10000'(ns));
    e_s  = hd(10000'(q), 10000'(s));
    q_a = q; ns_a = ns; s_a = s; en_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b0;
    chk({tag, " done_low"}, 32'(done_a), 32'd0);
    wait_done(0, 20, edges);
    chk({tag, " latency"}, edges, 11);
    chk({tag, " dist_ns"}, 32'(dns_a), e_ns);
    chk({tag, " dist_s"}, 32'(ds_a), e_s);
    chk({tag, " label"}, 32'(label_a), (e_s < e_ns) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [99:0] x, ea_q, ea_ns, ea_s, eb_q, eb_ns, eb_s;
    int edges, e_ns, e_s;

    nrst = 1'b0;
    en_a = 1'b0; q_a = '0; ns_a = '0; s_a = '0;
    en_b = 1'b0; q_b = '0; ns_b = '0; s_b = '0;
    en_c = 1'b0; q_c = '0; ns_c = '0; s_c = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset done", 32'(done_a), 32'd1);
    chk("reset label", 32'(label_a), 32'd0);
    chk("reset dist_ns", 32'(dns_a), 32'd0);
    chk("reset dist_s", 32'(ds_a), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Exact match with seizure, complete mismatch with nonseizure
    x = rand100();
    run_a("exact", x, ~x, x);
    chk("exact dist_ns_const", 32'(dns_a), 32'd100);
    chk("exact label_const", 32'(label_a), 32'd1);

    // Tie: both classes differ from the query in 10 bits
    run_a("tie", '0, 100'h3FF, {10'h3FF, 90'd0});
    chk("tie label_const", 32'(label_a), 32'd0);

    // Partial last chunk on the 95-bit instance
    q_b = '1; ns_b = '0; s_b = '1; en_b = 1'b1;
    @(posedge clk); #1;
    en_b = 1'b0;
    wait_done(1, 20, edges);
    chk("partial latency", edges, 11);
    chk("partial dist_ns", 32'(dns_b), 32'd95);
    chk("partial dist_s", 32'(ds_b), 32'd0);
    chk("partial label", 32'(label_b), 32'd1);
    chk("partial no_x", 32'($isunknown({done_b, label_b, dns_b, ds_b})), 32'd0);

    // Busy/latching: en held high, inputs scrambled after every latch
    ea_q = rand100(); ea_ns = rand100(); ea_s = rand100();
    eb_q = rand100(); eb_ns = ~eb_q; eb_s = eb_q ^ 100'hF;
    q_a = ea_q; ns_a = ea_ns; s_a = ea_s; en_a = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    do begin
      q_a = rand100(); ns_a = rand100(); s_a = rand100();
      @(posedge clk); #1;
      edges++;
    end while (!done_a && edges < 40);
    e_ns = hd(10000'(ea_q), 10000'(ea_ns));
    e_s  = hd(10000'(ea_q), 10000'(ea_s));
    chk("latch1 latency", edges, 11);
    chk("latch1 dist_ns", 32'(dns_a), e_ns);
    chk("latch1 dist_s", 32'(ds_a), e_s);
    chk("latch1 label", 32'(label_a), (e_s < e_ns) ? 32'd1 : 32'd0);
    q_a = eb_q; ns_a = eb_ns; s_a = eb_s;
    @(posedge clk); #1;
    edges++;
    chk("latch2 started", 32'(done_a), 32'd0);
    do begin
      q_a = rand100(); ns_a = rand100(); s_a = rand100();
      @(posedge clk); #1;
      edges++;
    end while (!done_a && edges < 60);
    en_a = 1'b0;
    chk("latch2 total_edges", edges + 1, 24);
    chk("latch2 dist_ns", 32'(dns_a), 32'd100);
    chk("latch2 dist_s", 32'(ds_a), 32'd4);
    chk("latch2 label", 32'(label_a), 32'd1);

    // Reset in the 5th compare cycle
    @(negedge clk);
    q_a = rand100(); ns_a = ~q_a; s_a = q_a; en_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("midrst done", 32'(done_a), 32'd1);
    chk("midrst label", 32'(label_a), 32'd0);
    chk("midrst dist_ns", 32'(dns_a), 32'd0);
    chk("midrst dist_s", 32'(ds_a), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    x = rand100();
    run_a("postrst", x, x, ~x);
    chk("postrst dist_ns_const", 32'(dns_a), 32'd0);
    chk("postrst label_const", 32'(label_a), 32'd0);

    // Default-size regression against the reference popcount
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      for (int i = 0; i < 10000; i++) begin
        q_c[i]  = 1'($urandom_range(0, 1));
        ns_c[i] = 1'($urandom_range(0, 1));
        s_c[i]  = 1'($urandom_range(0, 1));
      end
      e_ns = hd(q_c, ns_c);
      e_s  = hd(q_c, s_c);
      en_c = 1'b1;
      @(posedge clk); #1;
      en_c = 1'b0;
      wait_done(2, 1010, edges);
      chk($sformatf("big%0d latency", t), edges, 1001);
      chk($sformatf("big%0d dist_ns", t), 32'(dns_c), e_ns);
      chk($sformatf("big%0d dist_s", t), 32'(ds_c), e_s);
      chk($sformatf("big%0d label", t), 32'(label_c), (e_s < e_ns) ? 32'd1 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/assoc_search.md
Name: assoc_search

Overview:
- Inference-side reader of the two class hypervectors built by the training memory.
- Compares a query HV against the nonseizure and seizure class HVs by Hamming distance, PAR_BITS bits per cycle.
- Reports both distances and the predicted label, using the same en/done handshake as the training memory, so the top-level can run train and classify with one control style.

Parameters:
- DIMENSIONS, 10000, hypervector width in bits.
- PAR_BITS, 10, bits compared per class per cycle.
- NUM_CHUNKS, derived localparam = ceil(DIMENSIONS/PAR_BITS), not overridable.
- DIST_W, derived localparam = $clog2(DIMENSIONS+1), distance counter width.

Ports:
- clk  input  1  clock.
- nrst  input  1  reset, asynchronous, active-low.
- en  input  1  start request; sampled only when idle.
- hv_query  input  DIMENSIONS  encoded query HV.
- hv_nonseizure  input  DIMENSIONS  class HV for label 0.
- hv_seizure  input  DIMENSIONS  class HV for label 1.
- done  output  1  high = idle, results valid.
- label  output  1  predicted class: 0 nonseizure, 1 seizure.
- dist_nonseizure  output  DIST_W  Hamming distance query vs nonseizure.
- dist_seizure  output  DIST_W  Hamming distance query vs seizure.

Behaviour:
- Clock and reset: clk with nrst, asynchronous, active-low.
- Reset values: done=1, label=0, dist_nonseizure=0, dist_seizure=0, state=IDLE, chunk index=0, accumulators=0. Reset mid-operation aborts the operation; no partial result is exposed.
- States:
  - IDLE: if en, then
    - latch hv_query, hv_nonseizure, hv_seizure into internal registers;
    - clear both accumulators; set chunk=0; done<=0;
    - go to COMPARE.
    - en low: hold; outputs keep their last values.
  - COMPARE: each edge, for chunk c:
    - acc_ns += popcount(q[c*P +: P] ^ ns[c*P +: P]);
    - acc_s += popcount(q[c*P +: P] ^ s[c*P +: P]);
    - chunk++.
    - On the edge processing chunk NUM_CHUNKS-1, go to RESOLVE.
  - RESOLVE:
    - dist_nonseizure<=acc_ns; dist_seizure<=acc_s;
    - label<=(acc_s < acc_ns);
    - done<=1; go to IDLE.
- Tie: equal distances give label=0 (nonseizure preferred).
- Latency: en sampled on edge E0. Done and results update on edge E0+NUM_CHUNKS+1. Default: 1001 edges.
- Throughput: en high on the first IDLE cycle after done rises is accepted. Back-to-back ops are separated by exactly one IDLE cycle.
- en while busy (done=0) is ignored; it is not queued.
- Operands are latched at E0. Input changes during COMPARE/RESOLVE have no effect.
- Outputs are stable between operations and change only in RESOLVE.
- Partial last chunk (DIMENSIONS % PAR_BITS != 0):
  - bit positions >= DIMENSIONS are masked to zero before popcount;
  - no out-of-range indexing.
- Width rules:
  - per-chunk popcount width $clog2(PAR_BITS+1);
  - accumulators DIST_W bits, zero-extended add;
  - max value DIMENSIONS, so no overflow is possible.
- The block never drives the class memory; it only reads class HVs presented on its inputs.

Decomposition:
- hdc_pkg holds:
  - default DIMENSIONS and PAR_BITS constants;
  - label constants LABEL_NONSEIZURE=1'b0, LABEL_SEIZURE=1'b1;
  - state enum {IDLE, COMPARE, RESOLVE}.
- One combinational sub-module, hv_chunk_hamming:
  - parameters PAR_BITS and VALID_BITS mask;
  - inputs two PAR_BITS slices plus a valid-bit mask;
  - output popcount of masked XOR.
  - Instantiated twice, once per class.

Test Plan:
- Bench defaults are DIMENSIONS=100, PAR_BITS=10 (NUM_CHUNKS=10), except scenario 3.
- Exact match: query=seizure=random X, nonseizure=~X, en pulse -> done falls next edge, rises 11 edges after E0; dist_seizure=0, dist_nonseizure=100, label=1.
- Tie: query=0, nonseizure=bits[9:0] set, seizure=bits[99:90] set -> both distances 10, label=0.
- Partial chunk: DIMENSIONS=95, PAR_BITS=10, query=all ones, nonseizure=0, seizure=all ones -> dist_nonseizure=95, dist_seizure=0, label=1, done after 11 edges, no X on outputs.
- Busy/latching: en held high throughout; inputs randomised every cycle after E0 -> result matches operands at E0. Second op starts on the first idle cycle; two results take 24 edges total.
- Reset mid-op: assert nrst low during 5th COMPARE cycle -> immediately done=1, label=0, both distances 0. After release, a fresh op with query=nonseizure gives dist_nonseizure=0, label=0.
- Default-parameter regression: DIMENSIONS=10000, PAR_BITS=10, 50 random triples vs. reference popcount model -> exact distance/label match, each op done 1001 edges after en.
